// File: rtl/fetch_buffer.sv
// fetch_buffer: three-wide in-order instruction queue between fetch and dispatch.
// Define FB_BYPASS_EN to let an empty buffer forward fetch packets to dispatch in the same cycle.
package fetch_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] npc;
    logic [31:0] pc;
  } IF_ID_PACKET;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int FB_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  IF_ID_PACKET [2:0]          if_packet_in,
  output logic                       fb_stall,
  output IF_ID_PACKET [2:0]          if_id_packet_out,
  input  logic [2:0]                 d_stall,
  output logic [$clog2(FB_DEPTH):0]  fb_count
);
  localparam int AW = $clog2(FB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

  IF_ID_PACKET   r_entry [FB_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [1:0]    w_pos [3];
  logic [1:0]    w_in_n;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_n;
  logic [1:0]    w_skip;
  logic [2:0]    w_out_valid;
  logic [2:0]    w_take;
  logic [2:0]    w_we;
  logic [AW-1:0] w_waddr [3];
  IF_ID_PACKET   w_src [3];

  // Compacted position of each input slot among the valid ones.
  assign w_pos[0] = 2'd0;
  assign w_pos[1] = {1'b0, if_packet_in[0].valid};
  assign w_pos[2] = {1'b0, if_packet_in[0].valid} + {1'b0, if_packet_in[1].valid};
  assign w_in_n   = w_pos[2] + {1'b0, if_packet_in[2].valid};

  assign fb_stall = (DEPTH_C - r_count) < CW'(3);
  assign w_push_n = fb_stall ? 2'd0 : w_in_n;
  assign fb_count = r_count;

`ifdef FB_BYPASS_EN
  logic        w_bypass;
  IF_ID_PACKET w_comp [3];

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      w_comp[j] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      if (if_packet_in[k].valid) begin
        w_comp[w_pos[k]] = if_packet_in[k];
      end
    end
  end

  assign w_bypass = (r_count == '0) & ~squash & ~reset & ~fb_stall;
  // Bypassed packets taken by dispatch never enter the array.
  assign w_skip   = w_bypass ? w_pop_n : 2'd0;
`else
  assign w_skip   = 2'd0;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
`ifdef FB_BYPASS_EN
      assign w_src[gi]       = w_bypass ? w_comp[gi] : r_entry[r_head + AW'(gi)];
      assign w_out_valid[gi] = w_bypass ? (w_in_n > 2'(gi)) : (r_count > CW'(gi));
`else
      assign w_src[gi]       = r_entry[r_head + AW'(gi)];
      assign w_out_valid[gi] = r_count > CW'(gi);
`endif
      assign w_take[gi]  = w_out_valid[gi] & ~d_stall[gi];
      assign w_we[gi]    = if_packet_in[gi].valid & ~fb_stall & ~reset & ~squash
                           & (w_pos[gi] >= w_skip);
      assign w_waddr[gi] = r_tail + AW'(w_pos[gi] - w_skip);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if_id_packet_out[i] = '0;
      if (w_out_valid[i]) begin
        if_id_packet_out[i]       = w_src[i];
        if_id_packet_out[i].valid = 1'b1;
      end
    end
  end

  // Only the leading run of consumable slots is popped.
  always_comb begin
    w_pop_n = 2'd0;
    if (w_take[0]) begin
      w_pop_n = 2'd1;
      if (w_take[1]) begin
        w_pop_n = 2'd2;
        if (w_take[2]) begin
          w_pop_n = 2'd3;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (w_we[k]) begin
        r_entry[w_waddr[k]] <= if_packet_in[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop_n - w_skip);
      r_tail  <= r_tail + AW'(w_push_n - w_skip);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end
endmodule
